output_mem: RTL and testbench

Tile output buffer for the rotate engine, the write-back counterpart of the input tile buffer. It collects rotated pixels from the core one BGR triplet per cycle into a 192-byte tile store (64 pixels × 3 bytes). It then packs the tile into little-endian 32-bit words and presents them, one word per pop, to the AHB master's write data phase (HWDATA). It handles full and partial edge tiles, zero-filling the unused bytes of the last word.

---
 rtl/output_mem_pkg.sv | 22 ++
 rtl/output_mem_if.sv | 26 ++
 rtl/output_mem_word_mux.sv | 23 ++
 rtl/output_mem.sv | 110 +++++++++++
 tb/tb_output_mem.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/output_mem_pkg.sv
// Shared rotate-engine definitions for the tile output buffer: sizes, FSM
// encoding and the packed word count helper.
package output_mem_pkg;

  localparam int unsigned OMEM_BYTES   = 192;
  localparam int unsigned TILE_PIX_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } omem_state_t;

  // ceil(3N/4) for N in 1..64; at most 48 words
  function automatic logic [5:0] omem_word_count(input logic [6:0] n);
    logic [7:0] t;
    t = {1'b0, n} + {n, 1'b0} + 8'd3;
    return t[7:2];
  endfunction

endpackage

// File: rtl/output_mem_if.sv
// Pixel ingress from the rotate core and packed-word egress to the AHB master.
interface output_mem_if;
  logic        start;
  logic [6:0]  tile_pix;
  logic [7:0]  pixel_b;
  logic [7:0]  pixel_g;
  logic [7:0]  pixel_r;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wnext;
  logic [5:0]  wcount;
  logic        busy;
  logic        done;

  modport master (
    output start, tile_pix, pixel_b, pixel_g, pixel_r, pixel_valid, wnext,
    input  pixel_ready, wdata, wvalid, wcount, busy, done
  );

  modport slave (
    input  start, tile_pix, pixel_b, pixel_g, pixel_r, pixel_valid, wnext,
    output pixel_ready, wdata, wvalid, wcount, busy, done
  );
endinterface

// File: rtl/output_mem_word_mux.sv
// Packs four store bytes into a little-endian word; bytes at or past the
// tile's byte limit read as zero so stale store contents never leak out.
module omem_word_mux
  import output_mem_pkg::*;
(
  input  logic [7:0]  store [OMEM_BYTES],
  input  logic [5:0]  word_idx,
  input  logic [7:0]  byte_lim,
  output logic [31:0] word
);

  logic [7:0] idx;

  always_comb begin
    word = '0;
    idx  = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      idx = {word_idx, 2'b00} + 8'(b);
      if (idx < byte_lim) word[8*b +: 8] = store[idx];
    end
  end

endmodule

// File: rtl/output_mem.sv
// Tile output buffer: collects BGR pixels into a 192-byte store, then streams
// the tile out as zero-padded little-endian 32-bit words.
module output_mem
  import output_mem_pkg::*;
(
  input  logic         I_OMEM_HCLK,
  input  logic         I_OMEM_HRESET,
  output_mem_if.slave  omem
);

  omem_state_t state;
  logic [6:0]  n_pix;
  logic [6:0]  wr_pix;
  logic [5:0]  rd_ptr;
  logic [7:0]  byte_lim;
  logic [7:0]  store [OMEM_BYTES];

  logic [6:0]  n_clamp;
  logic [7:0]  wr_base;
  logic [5:0]  mux_idx;
  logic [31:0] mux_word;
  logic        pix_fire;
  logic        pop;

  assign n_clamp  = (omem.tile_pix == '0 || omem.tile_pix > 7'(TILE_PIX_MAX))
                    ? 7'(TILE_PIX_MAX) : omem.tile_pix;
  assign wr_base  = {1'b0, wr_pix} + {wr_pix, 1'b0};
  assign pix_fire = (state == ST_FILL) && omem.pixel_valid && omem.pixel_ready;
  assign pop      = (state == ST_DRAIN) && omem.wnext && omem.wvalid;
  // One mux serves both the first word (LOAD) and the look-ahead word (DRAIN)
  assign mux_idx  = (state == ST_LOAD) ? '0 : rd_ptr + 6'd1;

  omem_word_mux u_word_mux (
    .store    (store),
    .word_idx (mux_idx),
    .byte_lim (byte_lim),
    .word     (mux_word)
  );

  // Store is intentionally never cleared; the mux masks unused bytes.
  always_ff @(posedge I_OMEM_HCLK) begin
    if (!I_OMEM_HRESET && pix_fire) begin
      store[wr_base]        <= omem.pixel_b;
      store[wr_base + 8'd1] <= omem.pixel_g;
      store[wr_base + 8'd2] <= omem.pixel_r;
    end
  end

  always_ff @(posedge I_OMEM_HCLK) begin
    if (I_OMEM_HRESET) begin
      state            <= ST_IDLE;
      n_pix            <= '0;
      wr_pix           <= '0;
      rd_ptr           <= '0;
      byte_lim         <= '0;
      omem.pixel_ready <= 1'b0;
      omem.wdata       <= '0;
      omem.wvalid      <= 1'b0;
      omem.wcount      <= '0;
      omem.busy        <= 1'b0;
      omem.done        <= 1'b0;
    end else begin
      omem.done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (omem.start) begin
            n_pix            <= n_clamp;
            byte_lim         <= {1'b0, n_clamp} + {n_clamp, 1'b0};
            omem.wcount      <= omem_word_count(n_clamp);
            wr_pix           <= '0;
            rd_ptr           <= '0;
            omem.pixel_ready <= 1'b1;
            omem.busy        <= 1'b1;
            state            <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (pix_fire) begin
            wr_pix <= wr_pix + 7'd1;
            if (wr_pix == n_pix - 7'd1) begin
              omem.pixel_ready <= 1'b0;
              state            <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          omem.wdata  <= mux_word;
          omem.wvalid <= 1'b1;
          state       <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop) begin
            if (rd_ptr < omem.wcount - 6'd1) begin
              rd_ptr     <= rd_ptr + 6'd1;
              omem.wdata <= mux_word;
            end else begin
              omem.wvalid <= 1'b0;
              omem.wdata  <= '0;
              omem.done   <= 1'b1;
              omem.busy   <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_mem.sv
// Directed bench for output_mem: table of tiles with hand-computed word values,
// plus reset and back-to-back sequences.
module tb_output_mem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_mem_if bus();

  output_mem dut (
    .I_OMEM_HCLK   (clk),
    .I_OMEM_HRESET (rst),
    .omem          (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0]  n;
    int          mode;   // 0: B=i,G=40+i,R=80+i  1: bytes base+j  2: AA,BB,CC
    logic [7:0]  base;
    logic [5:0]  wc;
    logic [31:0] w0;
    logic [31:0] wl;
    bit          noisy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int mode, input logic [7:0] base, input int j);
    case (mode)
      0: case (j % 3)
           0:       return 8'(j / 3);
           1:       return 8'(8'h40 + j / 3);
           default: return 8'(8'h80 + j / 3);
         endcase
      1: return 8'(int'(base) + j);
      default: case (j % 3)
           0:       return 8'hAA;
           1:       return 8'hBB;
           default: return 8'hCC;
         endcase
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int mode, input logic [7:0] base,
                                           input int nbytes, input int k);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++)
      if (4*k + b < nbytes) w[8*b +: 8] = byte_at(mode, base, 4*k + b);
    return w;
  endfunction

  // Entered and left at a negedge; leaves the DONE cycle on the bus.
  task automatic run_tile(input vec_t v, input string tag);
    int neff, wce, p, k, cyc;
    bit acc;
    neff = (v.n == 0 || v.n > 64) ? 64 : int'(v.n);
    wce  = (3*neff + 3) / 4;
    bus.start = 1'b1; bus.tile_pix = v.n; bus.pixel_valid = 1'b0; bus.wnext = v.noisy;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " busy@fill"},  32'(bus.busy), 32'd1);
    check({tag, " ready@fill"}, 32'(bus.pixel_ready), 32'd1);
    check({tag, " done@fill"},  32'(bus.done), 32'd0);
    check({tag, " wvalid@fill"}, 32'(bus.wvalid), 32'd0);
    p = 0; cyc = 0;
    while (p < neff && cyc < 2000) begin
      if (v.noisy && $urandom_range(0, 2) == 0) begin
        bus.pixel_valid = 1'b0;
        bus.pixel_b = 8'hEE; bus.pixel_g = 8'hEE; bus.pixel_r = 8'hEE;
      end else begin
        bus.pixel_valid = 1'b1;
        bus.pixel_b = byte_at(v.mode, v.base, 3*p);
        bus.pixel_g = byte_at(v.mode, v.base, 3*p + 1);
        bus.pixel_r = byte_at(v.mode, v.base, 3*p + 2);
      end
      if (v.noisy) begin
        bus.start = 1'($urandom_range(0, 1)); bus.tile_pix = 7'd3;
        bus.wnext = 1'($urandom_range(0, 1));
      end
      acc = bus.pixel_ready && bus.pixel_valid;
      @(negedge clk); cyc++;
      if (acc) p++;
    end
    check({tag, " pixels accepted"}, 32'(p), 32'(neff));
    // LOAD cycle: junk pixels and a stray START must be ignored from here on
    bus.pixel_valid = v.noisy; bus.pixel_b = 8'hEE; bus.pixel_g = 8'hEE; bus.pixel_r = 8'hEE;
    bus.start = v.noisy; bus.wnext = 1'b0;
    check({tag, " ready@load"},  32'(bus.pixel_ready), 32'd0);
    check({tag, " wvalid@load"}, 32'(bus.wvalid), 32'd0);
    @(negedge clk);
    check({tag, " wcount"}, 32'(bus.wcount), 32'(v.wc));
    check({tag, " word0"},  bus.wdata, v.w0);
    k = 0; cyc = 0;
    while (k < wce && cyc < 4000) begin
      check({tag, " wvalid@drain"}, 32'(bus.wvalid), 32'd1);
      check({tag, " wdata"}, bus.wdata, exp_word(v.mode, v.base, 3*neff, k));
      check({tag, " done@drain"}, 32'(bus.done), 32'd0);
      if (k == wce - 1) check({tag, " last word"}, bus.wdata, v.wl);
      bus.wnext = v.noisy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.noisy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.pixel_valid = 1'($urandom_range(0, 1));
      end
      acc = bus.wnext;
      @(negedge clk); cyc++;
      if (acc) k++;
    end
    check({tag, " words popped"}, 32'(k), 32'(wce));
    bus.wnext = 1'b0; bus.pixel_valid = 1'b0; bus.start = 1'b0;
    check({tag, " done pulse"}, 32'(bus.done), 32'd1);
    check({tag, " busy@done"}, 32'(bus.busy), 32'd0);
    check({tag, " wvalid@done"}, 32'(bus.wvalid), 32'd0);
    check({tag, " wdata@done"}, bus.wdata, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{7'd64,  0, 8'h00, 6'd48, 32'h01804000, 32'hBF7F3FBE, 1'b0};
    vecs[1] = '{7'd5,   1, 8'h01, 6'd4,  32'h04030201, 32'h000F0E0D, 1'b1};
    vecs[2] = '{7'd1,   2, 8'h00, 6'd1,  32'h00CCBBAA, 32'h00CCBBAA, 1'b0};
    vecs[3] = '{7'd0,   1, 8'h00, 6'd48, 32'h03020100, 32'hBFBEBDBC, 1'b1};
    vecs[4] = '{7'd100, 1, 8'h10, 6'd48, 32'h13121110, 32'hCFCECDCC, 1'b0};
    vecs[5] = '{7'd2,   1, 8'h20, 6'd2,  32'h23222120, 32'h00002524, 1'b1};
    vecs[6] = '{7'd3,   1, 8'h50, 6'd3,  32'h53525150, 32'h00000058, 1'b0};
    vecs[7] = '{7'd4,   1, 8'h60, 6'd3,  32'h63626160, 32'h6B6A6968, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0; bus.tile_pix = '0; bus.pixel_valid = 1'b0;
    bus.pixel_b = '0; bus.pixel_g = '0; bus.pixel_r = '0; bus.wnext = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready",  32'(bus.pixel_ready), 32'd0);
    check("reset wdata",  bus.wdata, 32'd0);
    check("reset wvalid", 32'(bus.wvalid), 32'd0);
    check("reset wcount", 32'(bus.wcount), 32'd0);
    check("reset busy",   32'(bus.busy), 32'd0);
    check("reset done",   32'(bus.done), 32'd0);
    rst = 1'b0;

    bus.wnext = 1'b1;
    @(negedge clk);
    bus.wnext = 1'b0;
    check("idle wnext wvalid", 32'(bus.wvalid), 32'd0);
    check("idle wnext done",   32'(bus.done), 32'd0);

    // Back-to-back: each tile's START lands in the previous tile's DONE cycle
    for (int i = 0; i < 8; i++) run_tile(vecs[i], $sformatf("vec%0d", i));

    // Reset in mid-DRAIN abandons the tile without DONE
    bus.start = 1'b1; bus.tile_pix = 7'd64;
    @(negedge clk);
    bus.start = 1'b0;
    for (int p = 0; p < 64; p++) begin
      bus.pixel_valid = 1'b1;
      bus.pixel_b = 8'(p); bus.pixel_g = 8'(p); bus.pixel_r = 8'(p);
      @(negedge clk);
    end
    bus.pixel_valid = 1'b0;
    @(negedge clk);
    check("mid wvalid before reset", 32'(bus.wvalid), 32'd1);
    bus.wnext = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst ready",  32'(bus.pixel_ready), 32'd0);
    check("midrst wdata",  bus.wdata, 32'd0);
    check("midrst wvalid", 32'(bus.wvalid), 32'd0);
    check("midrst wcount", 32'(bus.wcount), 32'd0);
    check("midrst busy",   32'(bus.busy), 32'd0);
    check("midrst done",   32'(bus.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.wnext = 1'b0;
    check("after reset no done", 32'(bus.done), 32'd0);
    run_tile(vecs[1], "post-reset");

    // Simultaneous START and reset: reset wins
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.tile_pix = 7'd5;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("rst+start busy",  32'(bus.busy), 32'd0);
    check("rst+start ready", 32'(bus.pixel_ready), 32'd0);
    @(negedge clk);
    check("rst+start stays idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
